// File: rtl/fetch_hazard_ctrl.sv
// Fetch-stage hazard controller: sequences redirects, decompress retries and end-of-run drain,
// driving PC hold/redirect and IF/ID, ID/EX flushes. All outputs are registered.
module fetch_hazard_ctrl #(
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned MAX_RETRY    = 4
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        run_flag,
    input  logic        branch_mispredict,
    input  logic [31:0] branch_target,
    input  logic        decompress_failed,
    input  logic        run_finished_next,
    output logic        pc_hold,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        run_done,
    output logic        error,
    output logic [7:0]  flush_count
);

    typedef enum logic [2:0] {
        StIdle,
        StRun,
        StFlush,
        StRetry,
        StDrain,
        StDone
    } state_e;

    localparam logic [3:0] FlushInit = 4'(FLUSH_CYCLES - 1);
    localparam logic [3:0] DrainInit = 4'(DRAIN_CYCLES - 1);
    localparam logic [4:0] MaxRetry  = 5'(MAX_RETRY);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  retry_q, retry_d;
    logic [4:0]  retry_inc;
    logic        redirect;

    logic        pc_hold_q, pc_hold_d;
    logic        redirect_valid_q, redirect_valid_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        if_id_flush_q, if_id_flush_d;
    logic        id_ex_flush_q, id_ex_flush_d;
    logic        run_done_q, run_done_d;
    logic        error_q, error_d;
    logic [7:0]  flush_count_q, flush_count_d;

    assign retry_inc = {1'b0, retry_q} + 5'd1;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        retry_d       = retry_q;
        redirect      = 1'b0;
        error_d       = error_q;
        redirect_pc_d = redirect_pc_q;
        flush_count_d = flush_count_q;

        unique case (state_q)
            StIdle: begin
                if (run_flag) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (!decompress_failed) begin
                    retry_d = '0;
                end
                if (branch_mispredict) begin
                    redirect = 1'b1;
                end else if (decompress_failed) begin
                    retry_d = retry_inc[3:0];
                    if (retry_inc >= MaxRetry) begin
                        state_d = StDone;
                        error_d = 1'b1;
                    end else begin
                        state_d = StRetry;
                    end
                end else if (run_finished_next) begin
                    state_d = StDrain;
                    cnt_d   = DrainInit;
                end
            end
            StFlush: begin
                if (branch_mispredict) begin
                    redirect = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StRun;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StRetry: begin
                if (branch_mispredict) begin
                    redirect = 1'b1;
                end else begin
                    state_d = StRun;
                end
            end
            StDrain: begin
                if (branch_mispredict) begin
                    redirect = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StDone: begin
                if (!run_flag) begin
                    state_d = StIdle;
                    retry_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // A redirect from any active state restarts the flush window with the new target.
        if (redirect) begin
            state_d       = StFlush;
            cnt_d         = FlushInit;
            redirect_pc_d = branch_target;
            if (flush_count_q != 8'hFF) begin
                flush_count_d = flush_count_q + 8'd1;
            end
        end
    end

    // Output registers are loaded from the next state so they line up with it.
    always_comb begin
        pc_hold_d        = (state_d == StIdle) || (state_d == StRetry) ||
                           (state_d == StDrain) || (state_d == StDone);
        redirect_valid_d = redirect;
        if_id_flush_d    = (state_d == StFlush) || (state_d == StRetry);
        id_ex_flush_d    = (state_d == StFlush);
        run_done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q          <= StIdle;
            cnt_q            <= '0;
            retry_q          <= '0;
            pc_hold_q        <= 1'b1;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            if_id_flush_q    <= 1'b0;
            id_ex_flush_q    <= 1'b0;
            run_done_q       <= 1'b0;
            error_q          <= 1'b0;
            flush_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            retry_q          <= retry_d;
            pc_hold_q        <= pc_hold_d;
            redirect_valid_q <= redirect_valid_d;
            redirect_pc_q    <= redirect_pc_d;
            if_id_flush_q    <= if_id_flush_d;
            id_ex_flush_q    <= id_ex_flush_d;
            run_done_q       <= run_done_d;
            error_q          <= error_d;
            flush_count_q    <= flush_count_d;
        end
    end

    assign pc_hold        = pc_hold_q;
    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign if_id_flush    = if_id_flush_q;
    assign id_ex_flush    = id_ex_flush_q;
    assign run_done       = run_done_q;
    assign error          = error_q;
    assign flush_count    = flush_count_q;

endmodule

// File: tb/tb_fetch_hazard_ctrl.sv
// Randomized and directed bench for fetch_hazard_ctrl against a cycle-count reference model.
module tb_fetch_hazard_ctrl;

    localparam int FlushCycles = 2;
    localparam int DrainCycles = 3;
    localparam int MaxRetry    = 4;

    logic        clk = 1'b0;
    logic        rstn;
    logic        run_flag;
    logic        branch_mispredict;
    logic [31:0] branch_target;
    logic        decompress_failed;
    logic        run_finished_next;
    logic        pc_hold;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        run_done;
    logic        error;
    logic [7:0]  flush_count;

    int checks   = 0;
    int failures = 0;

    // Reference model: phase lengths tracked as remaining-cycle counts.
    bit          m_running, m_done, m_err, m_rv, m_retry_now;
    int          m_flush_left, m_drain_left, m_fails, m_fc;
    logic [31:0] m_rpc;

    fetch_hazard_ctrl #(
        .FLUSH_CYCLES(FlushCycles),
        .DRAIN_CYCLES(DrainCycles),
        .MAX_RETRY   (MaxRetry)
    ) dut (
        .clk              (clk),
        .rstn             (rstn),
        .run_flag         (run_flag),
        .branch_mispredict(branch_mispredict),
        .branch_target    (branch_target),
        .decompress_failed(decompress_failed),
        .run_finished_next(run_finished_next),
        .pc_hold          (pc_hold),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .if_id_flush      (if_id_flush),
        .id_ex_flush      (id_ex_flush),
        .run_done         (run_done),
        .error            (error),
        .flush_count      (flush_count)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_update();
        bit plain_run;
        m_rv = 1'b0;
        if (!rstn) begin
            m_running = 0; m_done = 0; m_err = 0; m_retry_now = 0;
            m_flush_left = 0; m_drain_left = 0; m_fails = 0; m_fc = 0; m_rpc = '0;
        end else if (!m_running && !m_done) begin
            if (run_flag) m_running = 1;
        end else if (m_done) begin
            if (!run_flag) begin
                m_done  = 0;
                m_fails = 0;
            end
        end else begin
            plain_run = (m_flush_left == 0) && !m_retry_now && (m_drain_left == 0);
            if (plain_run && !decompress_failed) m_fails = 0;
            if (branch_mispredict) begin
                m_rv = 1'b1;
                m_rpc = branch_target;
                m_flush_left = FlushCycles;
                m_drain_left = 0;
                m_retry_now = 0;
                m_fc = (m_fc < 255) ? m_fc + 1 : 255;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
            end else if (m_retry_now) begin
                m_retry_now = 0;
            end else if (m_drain_left > 0) begin
                m_drain_left--;
                if (m_drain_left == 0) begin
                    m_running = 0;
                    m_done = 1;
                end
            end else if (decompress_failed) begin
                m_fails++;
                if (m_fails >= MaxRetry) begin
                    m_err = 1;
                    m_running = 0;
                    m_done = 1;
                end else begin
                    m_retry_now = 1;
                end
            end else if (run_finished_next) begin
                m_drain_left = DrainCycles;
            end
        end
    endtask

    task automatic compare_all();
        check_eq("pc_hold", pc_hold, !m_running || m_retry_now || (m_drain_left > 0));
        check_eq("redirect_valid", redirect_valid, m_rv);
        check_eq("redirect_pc", redirect_pc, m_rpc);
        check_eq("if_id_flush", if_id_flush, (m_flush_left > 0) || m_retry_now);
        check_eq("id_ex_flush", id_ex_flush, m_flush_left > 0);
        check_eq("run_done", run_done, m_done);
        check_eq("error", error, m_err);
        check_eq("flush_count", flush_count, m_fc[7:0]);
    endtask

    task automatic step(input logic rf, input logic bm, input logic df, input logic rfn,
                        input logic [31:0] tgt, input logic rn);
        rstn = rn;
        run_flag = rf;
        branch_mispredict = bm;
        decompress_failed = df;
        run_finished_next = rfn;
        branch_target = tgt;
        @(posedge clk);
        model_update();
        #1;
        compare_all();
    endtask

    initial begin
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("reset_pc_hold", pc_hold, 1'b1);
        check_eq("reset_redirect_pc", redirect_pc, 32'h0);

        // Start, then a single mispredict.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("run_pc_hold", pc_hold, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_1040, 1'b1);
        check_eq("redir_valid", redirect_valid, 1'b1);
        check_eq("redir_pc_1040", redirect_pc, 32'h0000_1040);
        check_eq("redir_fc1", flush_count, 8'd1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("flush2_id_ex", id_ex_flush, 1'b1);
        check_eq("flush2_rv", redirect_valid, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("flush_end", if_id_flush, 1'b0);

        // Decompress failures held until the retry limit trips.
        for (int i = 0; i < 2 * MaxRetry - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("retry_error", error, 1'b1);
        check_eq("retry_done", run_done, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("done_to_idle", run_done, 1'b0);
        check_eq("error_sticky", error, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // Drain aborted on its second cycle, then a full drain.
        step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0000_2000, 1'b1);
        check_eq("drain_abort_rv", redirect_valid, 1'b1);
        for (int i = 0; i < FlushCycles; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 1'b1);
        for (int i = 0; i < DrainCycles - 1; i++) step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 1'b1);
        check_eq("drain_not_done", run_done, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        check_eq("drain_done", run_done, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);

        // All three events at once: only the redirect response.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 1'b1);
        check_eq("prio_rv", redirect_valid, 1'b1);
        check_eq("prio_pc_hold", pc_hold, 1'b0);

        // Reset in the middle of a flush.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
        check_eq("rst_flush_if_id", if_id_flush, 1'b0);
        check_eq("rst_flush_id_ex", id_ex_flush, 1'b0);
        check_eq("rst_flush_fc", flush_count, 8'd0);
        check_eq("rst_flush_hold", pc_hold, 1'b1);

        // Back-to-back mispredicts saturate the redirect counter.
        step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
        for (int i = 0; i < 270; i++) step(1'b1, 1'b1, 1'b0, 1'b0, $urandom, 1'b1);
        check_eq("fc_saturate", flush_count, 8'd255);

        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 10,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 8,
                 $urandom, $urandom_range(0, 199) != 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
